// File: rtl/proc_control.sv
// Multi-cycle control unit for the 16-bit simple processor (mv, mvi, add, sub).
// Optional sticky undefined-opcode flag enabled by defining PROC_CTRL_ILLEGAL_EN.
module proc_control (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] DIN,
  output logic        IRin,
  output logic [7:0]  Rin,
  output logic [7:0]  Rout,
  output logic        DINout,
  output logic        Gout,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        Done,
  output logic        Illegal
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_e     state_q, state_d;
  logic [8:0] ir_q, ir_d;
  logic [2:0] opcode;
  logic [7:0] x_oh, y_oh;
  logic       unused_din_hi;

  assign unused_din_hi = ^DIN[15:9];
  assign opcode        = ir_q[8:6];
  assign x_oh          = 8'b1 << ir_q[5:3];
  assign y_oh          = 8'b1 << ir_q[2:0];

`ifdef PROC_CTRL_ILLEGAL_EN
  logic illegal_q, illegal_d;
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
`ifdef PROC_CTRL_ILLEGAL_EN
    illegal_d = illegal_q;
`endif
    IRin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    DINout = 1'b0;
    Gout   = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;

    unique case (state_q)
      T0: begin
        IRin = Run;
        if (Run) begin
          ir_d    = DIN[8:0];
          state_d = T1;
        end
      end
      T1: begin
        unique case (opcode)
          OP_MV: begin
            Rout    = y_oh;
            Rin     = x_oh;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            Rin     = x_oh;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            Rout    = x_oh;
            Ain     = 1'b1;
            state_d = T2;
          end
          default: begin
            Done    = 1'b1;
            state_d = T0;
`ifdef PROC_CTRL_ILLEGAL_EN
            illegal_d = 1'b1;
`endif
          end
        endcase
      end
      T2: begin
        Rout    = y_oh;
        Gin     = 1'b1;
        AddSub  = opcode[0];
        state_d = T3;
      end
      T3: begin
        Gout    = 1'b1;
        Rin     = x_oh;
        Done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase

    // Reset silences every strobe immediately, including the Run-driven IRin.
    if (!Resetn) begin
      IRin   = 1'b0;
      Rin    = '0;
      Rout   = '0;
      DINout = 1'b0;
      Gout   = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
`ifdef PROC_CTRL_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
`ifdef PROC_CTRL_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: per-instruction control sequences plus a
// small datapath whose register contents are compared with an instruction-level model.
module tb_proc_control;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        IRin;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        DINout, Gout, Ain, Gin, AddSub, Done, Illegal;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] dp_r [8] = '{default: '0};
  logic [15:0] dp_a = '0;
  logic [15:0] dp_g = '0;
  logic [15:0] bus;
  logic [15:0] ref_r [8] = '{default: '0};
  logic        ill_model = 1'b0;
  logic [22:0] obs;

  proc_control dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .DIN     (DIN),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .DINout  (DINout),
    .Gout    (Gout),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .Done    (Done),
    .Illegal (Illegal)
  );

  always #5 Clock = ~Clock;

  assign obs = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};

  // Downstream datapath driven by the control strobes.
  always_comb begin
    bus = '0;
    if (DINout) bus = DIN;
    else if (Gout) bus = dp_g;
    for (int i = 0; i < 8; i++)
      if (Rout[i]) bus = dp_r[i];
  end

  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++)
      if (Rin[i]) dp_r[i] <= bus;
    if (Ain) dp_a <= bus;
    if (Gin) dp_g <= AddSub ? dp_a - bus : dp_a + bus;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] ctrl(input logic irin, input logic [7:0] rin,
                                        input logic [7:0] rout, input logic dinout,
                                        input logic gout, input logic ain, input logic gin,
                                        input logic addsub, input logic done);
    return {irin, rin, rout, dinout, gout, ain, gin, addsub, done};
  endfunction

  function automatic logic expected_illegal();
`ifdef PROC_CTRL_ILLEGAL_EN
    return ill_model;
`else
    return 1'b0;
`endif
  endfunction

  // Entered and left at posedge+1; the next instruction may issue immediately.
  task automatic exec(input logic [15:0] instr, input logic [15:0] imm);
    logic [2:0]  op, x, y;
    logic [7:0]  xo, yo;
    logic [15:0] res;
    op = instr[8:6];
    x  = instr[5:3];
    y  = instr[2:0];
    xo = 8'b1 << x;
    yo = 8'b1 << y;
    Run = 1'b1;
    DIN = instr;
    @(negedge Clock);
    check("T0_ctrl", 32'(obs), 32'(ctrl(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    check("T0_illegal", 32'(Illegal), 32'(expected_illegal()));
    @(posedge Clock); #1;
    Run = 1'($urandom);
    DIN = imm;
    @(negedge Clock);
    case (op)
      3'd0:    check("T1_mv",  32'(obs), 32'(ctrl(0, xo, yo, 0, 0, 0, 0, 0, 1)));
      3'd1:    check("T1_mvi", 32'(obs), 32'(ctrl(0, xo, 0, 1, 0, 0, 0, 0, 1)));
      3'd2,
      3'd3:    check("T1_alu", 32'(obs), 32'(ctrl(0, 0, xo, 0, 0, 1, 0, 0, 0)));
      default: check("T1_nop", 32'(obs), 32'(ctrl(0, 0, 0, 0, 0, 0, 0, 0, 1)));
    endcase
    case (op)
      3'd0:    res = ref_r[y];
      3'd1:    res = imm;
      3'd2:    res = ref_r[x] + ref_r[y];
      3'd3:    res = ref_r[x] - ref_r[y];
      default: res = ref_r[x];
    endcase
    if (op == 3'd2 || op == 3'd3) begin
      @(posedge Clock); #1;
      Run = 1'($urandom);
      DIN = 16'($urandom);
      @(negedge Clock);
      check("T2_ctrl", 32'(obs), 32'(ctrl(0, 0, yo, 0, 0, 0, 1, op[0], 0)));
      @(posedge Clock); #1;
      Run = 1'($urandom);
      @(negedge Clock);
      check("T3_ctrl", 32'(obs), 32'(ctrl(0, xo, 0, 0, 1, 0, 0, 0, 1)));
    end
    if (op[2]) ill_model = 1'b1;
    else ref_r[x] = res;
    @(posedge Clock); #1;
    Run = 1'b0;
    check("reg_result", 32'(dp_r[x]), 32'(ref_r[x]));
    check("illegal_flag", 32'(Illegal), 32'(expected_illegal()));
  endtask

  task automatic idle(input int unsigned n);
    Run = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      DIN = 16'($urandom);
      @(negedge Clock);
      check("idle_ctrl", 32'(obs), 32'd0);
      @(posedge Clock); #1;
    end
  endtask

  task automatic reset_mid_add();
    Run = 1'b1;
    DIN = 16'h008A;
    @(negedge Clock);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    #2;
    Resetn = 1'b0;
    #1;
    check("rst_async_ctrl", 32'(obs), 32'd0);
    check("rst_async_illegal", 32'(Illegal), 32'd0);
    @(posedge Clock); #1;
    check("rst_hold_ctrl", 32'(obs), 32'd0);
    ill_model = 1'b0;
    Resetn = 1'b1;
    Run    = 1'b0;
    @(negedge Clock);
    check("rst_release_ctrl", 32'(obs), 32'd0);
    @(posedge Clock); #1;
    @(negedge Clock);
    check("rst_release_ctrl2", 32'(obs), 32'd0);
    @(posedge Clock); #1;
    check("rst_no_write", 32'(dp_r[1]), 32'(ref_r[1]));
    check("rst_illegal_clear", 32'(Illegal), 32'd0);
  endtask

  initial begin
    logic [15:0] instr;
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 16'h0048;
    #3;
    check("reset_ctrl", 32'(obs), 32'd0);
    check("reset_illegal", 32'(Illegal), 32'd0);
    @(posedge Clock); #1;
    check("reset_ctrl_edge", 32'(obs), 32'd0);
    Resetn = 1'b1;
    Run    = 1'b0;
    idle(2);

    exec(16'h0048, 16'h0005);
    check("mvi_r1", 32'(dp_r[1]), 32'h0005);
    exec(16'h0011, 16'($urandom));
    check("mv_r2", 32'(dp_r[2]), 32'h0005);
    exec(16'h0050, 16'h0003);
    exec(16'h008A, 16'($urandom));
    check("add_r1", 32'(dp_r[1]), 32'h0008);
    exec(16'h0048, 16'h0005);
    exec(16'h00CA, 16'($urandom));
    check("sub_r1", 32'(dp_r[1]), 32'h0002);
    exec(16'h0048, 16'h0003);
    exec(16'h0050, 16'h0005);
    exec(16'h00CA, 16'($urandom));
    check("sub_neg_r1", 32'(dp_r[1]), 32'hFFFE);
    exec(16'h008A, 16'($urandom));
    exec(16'h008A, 16'($urandom));
    exec(16'h0100, 16'($urandom));
    exec(16'h0011, 16'($urandom));
    reset_mid_add();

    for (int i = 0; i < 80; i++) begin
      instr    = 16'($urandom);
      instr[8] = ($urandom_range(0, 3) == 0);
      exec(instr, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
